// File: rtl/delay_timer_arbiter.sv
// Round-robin sharing of one countdown delay timer between NREQ requesters.
// Grant one cycle after the request is seen; done D+1 cycles after the grant.
module delay_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int CBITS = 10,
    parameter int MAXD  = 750,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IW-1:0]         done_id,
    output logic                  err,
    output logic                  abort
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     own_q, own_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;

    logic              win_vld;
    logic [IW-1:0]     win;
    logic [IW-1:0]     idx;
    logic [CBITS-1:0]  win_dly;
    logic              over;
    logic [IW-1:0]     ptr_nxt;

    // Scan downwards so the lowest rotated offset from ptr is the last match kept.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign win_dly = dly[win*CBITS +: CBITS];
    assign over    = (win_dly > CBITS'(MAXD));
    assign ptr_nxt = (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = COUNT;
                    own_d   = win;
                    cnt_d   = over ? CBITS'(MAXD) : win_dly;
                    err_d   = over;
                end
            end
            COUNT: begin
                // Abandon wins over expiry when both happen in the same cycle.
                if (!req[own_q]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    ptr_d   = ptr_nxt;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CBITS'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = ptr_nxt;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign gnt     = busy ? (NREQ'(1) << own_q) : '0;
    assign done    = done_q;
    assign done_id = own_q;
    assign err     = err_q;
    assign abort   = abort_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_busy_gnt:   assert property (@(posedge clk) disable iff (rst) busy == (gnt != '0));
    a_done_owner: assert property (@(posedge clk) disable iff (rst) done |-> (busy && gnt[done_id]));
    a_done_once:  assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_err_once:   assert property (@(posedge clk) disable iff (rst) err |=> !err);
    a_abort_once: assert property (@(posedge clk) disable iff (rst) abort |=> !abort);
    a_done_abort: assert property (@(posedge clk) disable iff (rst) !(done && abort));
    a_cnt_max:    assert property (@(posedge clk) disable iff (rst) cnt_q <= CBITS'(MAXD));

endmodule
